// File: rtl/rate_averaging_pkg.sv
// Shared types and default parameters for the rate tracking path.
package clks_alot_p;

  localparam int RATE_COUNTER_WIDTH             = 16;
  localparam int AVG_DEPTH_LOG2_DEFAULT         = 3;
  localparam int DRIFT_REJECT_THRESHOLD_DEFAULT = 8;
  localparam int REJECT_LIMIT_DEFAULT           = 3;

  typedef enum logic {
    DRIFT_SLOWER = 1'b0,
    DRIFT_FASTER = 1'b1
  } drift_direction_e;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    LOCKED  = 2'd2
  } rate_avg_state_e;

endpackage

// File: rtl/rate_averaging_ring.sv
// Circular buffer of accepted rate samples: write pointer, fill count and
// oldest-entry read used to slide the running sum.
module rate_sample_ring
  import clks_alot_p::*;
#(
  parameter int RATE_COUNTER_WIDTH = clks_alot_p::RATE_COUNTER_WIDTH,
  parameter int AVG_DEPTH_LOG2     = AVG_DEPTH_LOG2_DEFAULT
) (
  input  logic                          clk,
  input  logic                          sync_rst_n,
  input  logic                          clk_en,
  input  logic                          clear_i,
  input  logic                          write_i,
  input  logic                          restart_i,
  input  logic [RATE_COUNTER_WIDTH-1:0] sample_i,
  output logic [RATE_COUNTER_WIDTH-1:0] oldest_o,
  output logic [AVG_DEPTH_LOG2:0]       fill_count_o,
  output logic                          full_o
);

  localparam int DEPTH = 1 << AVG_DEPTH_LOG2;

  logic [RATE_COUNTER_WIDTH-1:0] ring_q [DEPTH];
  logic [AVG_DEPTH_LOG2-1:0]     wr_ptr_q;
  logic [AVG_DEPTH_LOG2:0]       fill_q;

  // Restart drops every old entry and seeds slot 0 with the new sample.
  always_ff @(posedge clk) begin
    if (!sync_rst_n || (clk_en && clear_i)) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (clk_en && restart_i) begin
      ring_q[0] <= sample_i;
      wr_ptr_q  <= AVG_DEPTH_LOG2'(1);
      fill_q    <= (AVG_DEPTH_LOG2+1)'(1);
    end else if (clk_en && write_i) begin
      ring_q[wr_ptr_q] <= sample_i;
      wr_ptr_q         <= wr_ptr_q + AVG_DEPTH_LOG2'(1);
      if (!full_o) fill_q <= fill_q + (AVG_DEPTH_LOG2+1)'(1);
    end
  end

  assign oldest_o     = ring_q[wr_ptr_q];
  assign fill_count_o = fill_q;
  assign full_o       = (fill_q == (AVG_DEPTH_LOG2+1)'(DEPTH));

endmodule

// File: rtl/rate_averaging.sv
// Moving-average smoother for measured periods with drift-based outlier
// rejection and automatic re-lock after a run of rejections.
module rate_averaging
  import clks_alot_p::*;
#(
  parameter int RATE_COUNTER_WIDTH     = clks_alot_p::RATE_COUNTER_WIDTH,
  parameter int AVG_DEPTH_LOG2         = AVG_DEPTH_LOG2_DEFAULT,
  parameter int DRIFT_REJECT_THRESHOLD = DRIFT_REJECT_THRESHOLD_DEFAULT,
  parameter int REJECT_LIMIT           = REJECT_LIMIT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          sync_rst_n,
  input  logic                          clk_en,
  input  logic                          averaging_en_i,
  input  logic                          clear_state_i,
  input  logic                          sample_valid_i,
  input  logic [RATE_COUNTER_WIDTH-1:0] sample_rate_i,
  input  logic                          drift_detected_i,
  input  drift_direction_e              drift_direction_i,
  input  logic [RATE_COUNTER_WIDTH-1:0] drift_amount_i,
  output logic                          average_valid_o,
  output logic [RATE_COUNTER_WIDTH-1:0] average_rate_o,
  output logic [AVG_DEPTH_LOG2:0]       fill_count_o,
  output logic                          sample_rejected_o,
  output drift_direction_e              reject_direction_o
);

  localparam int DEPTH = 1 << AVG_DEPTH_LOG2;
  localparam int SUM_W = RATE_COUNTER_WIDTH + AVG_DEPTH_LOG2;

  rate_avg_state_e               state_q, state_d;
  logic [SUM_W-1:0]              sum_q;
  logic [3:0]                    reject_cnt_q;
  logic                          rejected_q;
  drift_direction_e              reject_dir_q;
  logic [RATE_COUNTER_WIDTH-1:0] oldest;
  logic                          full;
  logic                          accept, reject, flush, store;

  assign accept = clk_en && averaging_en_i && sample_valid_i && !clear_state_i;
  assign reject = accept && (state_q == LOCKED) && drift_detected_i &&
                  (drift_amount_i > RATE_COUNTER_WIDTH'(DRIFT_REJECT_THRESHOLD));
  assign flush  = reject && ((reject_cnt_q + 4'd1) == 4'(REJECT_LIMIT));
  assign store  = accept && !reject;

  rate_sample_ring #(
    .RATE_COUNTER_WIDTH (RATE_COUNTER_WIDTH),
    .AVG_DEPTH_LOG2     (AVG_DEPTH_LOG2)
  ) u_ring (
    .clk          (clk),
    .sync_rst_n   (sync_rst_n),
    .clk_en       (clk_en),
    .clear_i      (clear_state_i),
    .write_i      (store),
    .restart_i    (flush),
    .sample_i     (sample_rate_i),
    .oldest_o     (oldest),
    .fill_count_o (fill_count_o),
    .full_o       (full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) state_q <= EMPTY;
    else if (clk_en) state_q <= state_d;
  end

  // Next-state: clear dominates, then fill progress and flush re-lock.
  always_comb begin
    state_d = state_q;
    if (clear_state_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (store) state_d = FILLING;
        FILLING: if (store && fill_count_o == (AVG_DEPTH_LOG2+1)'(DEPTH-1)) state_d = LOCKED;
        LOCKED:  if (flush) state_d = FILLING;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs derived from the registered state.
  always_comb begin
    average_valid_o = (state_q == LOCKED);
  end

  // Running sum: restart on flush, slide out the oldest entry once full.
  always_ff @(posedge clk) begin
    if (!sync_rst_n || (clk_en && clear_state_i)) begin
      sum_q <= '0;
    end else if (flush) begin
      sum_q <= SUM_W'(sample_rate_i);
    end else if (store) begin
      if (full) sum_q <= sum_q - SUM_W'(oldest) + SUM_W'(sample_rate_i);
      else      sum_q <= sum_q + SUM_W'(sample_rate_i);
    end
  end

  // Consecutive-rejection counter; any stored sample breaks the run.
  always_ff @(posedge clk) begin
    if (!sync_rst_n || (clk_en && clear_state_i)) begin
      reject_cnt_q <= '0;
    end else if (flush || store) begin
      reject_cnt_q <= '0;
    end else if (reject) begin
      reject_cnt_q <= reject_cnt_q + 4'd1;
    end
  end

  // Rejection pulse only follows an enabled cycle; direction is sticky.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      rejected_q   <= 1'b0;
      reject_dir_q <= DRIFT_SLOWER;
    end else if (!clk_en) begin
      rejected_q   <= 1'b0;
    end else if (clear_state_i) begin
      rejected_q   <= 1'b0;
      reject_dir_q <= DRIFT_SLOWER;
    end else begin
      rejected_q <= reject;
      if (reject) reject_dir_q <= drift_direction_i;
    end
  end

  assign average_rate_o     = RATE_COUNTER_WIDTH'(sum_q >> AVG_DEPTH_LOG2);
  assign sample_rejected_o  = rejected_q;
  assign reject_direction_o = reject_dir_q;

endmodule

// File: tb/tb_rate_averaging.sv
// Randomized and directed bench for rate_averaging with a queue-based
// window model and a decoupled scoreboard monitor.
module tb_rate_averaging;
  import clks_alot_p::*;

  localparam int W     = 16;
  localparam int L     = 2;
  localparam int DEPTH = 4;
  localparam int THR   = 8;
  localparam int LIM   = 3;

  logic             clk = 1'b0;
  logic             sync_rst_n = 1'b0;
  logic             clk_en = 1'b0;
  logic             averaging_en_i = 1'b0;
  logic             clear_state_i = 1'b0;
  logic             sample_valid_i = 1'b0;
  logic [W-1:0]     sample_rate_i = '0;
  logic             drift_detected_i = 1'b0;
  drift_direction_e drift_direction_i = DRIFT_SLOWER;
  logic [W-1:0]     drift_amount_i = '0;
  logic             average_valid_o;
  logic [W-1:0]     average_rate_o;
  logic [L:0]       fill_count_o;
  logic             sample_rejected_o;
  drift_direction_e reject_direction_o;

  rate_averaging #(
    .RATE_COUNTER_WIDTH     (W),
    .AVG_DEPTH_LOG2         (L),
    .DRIFT_REJECT_THRESHOLD (THR),
    .REJECT_LIMIT           (LIM)
  ) dut (
    .clk                (clk),
    .sync_rst_n         (sync_rst_n),
    .clk_en             (clk_en),
    .averaging_en_i     (averaging_en_i),
    .clear_state_i      (clear_state_i),
    .sample_valid_i     (sample_valid_i),
    .sample_rate_i      (sample_rate_i),
    .drift_detected_i   (drift_detected_i),
    .drift_direction_i  (drift_direction_i),
    .drift_amount_i     (drift_amount_i),
    .average_valid_o    (average_valid_o),
    .average_rate_o     (average_rate_o),
    .fill_count_o       (fill_count_o),
    .sample_rejected_o  (sample_rejected_o),
    .reject_direction_o (reject_direction_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    int         rate;
    int         fill;
    logic       rej;
    logic       dir;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the window is simply the list of samples held.
  int   win[$];
  int   rej_run = 0;
  logic m_rej = 1'b0;
  logic m_dir = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic en, input logic aen, input logic clr, input logic rstn,
                      input logic sv, input int rate, input logic dd, input logic dir,
                      input int amt);
    exp_t e;
    int   s;
    sync_rst_n        = rstn;
    clk_en            = en;
    averaging_en_i    = aen;
    clear_state_i     = clr;
    sample_valid_i    = sv;
    sample_rate_i     = W'(rate);
    drift_detected_i  = dd;
    drift_direction_i = drift_direction_e'(dir);
    drift_amount_i    = W'(amt);
    if (!rstn || (en && clr)) begin
      win.delete();
      rej_run = 0;
      m_rej   = 1'b0;
      m_dir   = 1'b0;
    end else if (!en) begin
      m_rej = 1'b0;
    end else begin
      m_rej = 1'b0;
      if (aen && sv) begin
        if (win.size() == DEPTH && dd && amt > THR) begin
          rej_run++;
          m_rej = 1'b1;
          m_dir = dir;
          if (rej_run == LIM) begin
            win.delete();
            win.push_back(rate);
            rej_run = 0;
          end
        end else begin
          rej_run = 0;
          if (win.size() == DEPTH) void'(win.pop_front());
          win.push_back(rate);
        end
      end
    end
    s = 0;
    foreach (win[i]) s += win[i];
    e.v    = (win.size() == DEPTH);
    e.rate = s / DEPTH;
    e.fill = win.size();
    e.rej  = m_rej;
    e.dir  = m_dir;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1, 1, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic smp(input int rate, input logic dd, input int amt);
    step(1, 1, 0, 1, 1, rate, dd, 1'b1, amt);
  endtask

  // Scoreboard monitor: one expectation per clock, compared mid-cycle.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("average_valid", int'(average_valid_o), int'(e.v));
      check("average_rate", int'(average_rate_o), e.rate);
      check("fill_count", int'(fill_count_o), e.fill);
      check("sample_rejected", int'(sample_rejected_o), int'(e.rej));
      check("reject_direction", int'(reject_direction_o), int'(e.dir));
    end
  end

  initial begin
    // Reset
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 77, 0, 0, 0);
    // Fill and slide
    smp(100, 0, 0); smp(102, 0, 0); smp(98, 0, 0); smp(100, 0, 0);
    idle();
    smp(104, 0, 0);
    // Outlier then normal sample
    smp(150, 1, 20);
    idle();
    smp(101, 0, 0);
    // Drift below threshold is still accepted when locked
    smp(99, 1, 8);
    // Re-lock after three rejections
    smp(200, 1, 50); smp(200, 1, 50); smp(200, 1, 50);
    smp(200, 0, 0); smp(200, 0, 0); smp(200, 0, 0);
    idle();
    // Clear beats a simultaneous sample
    step(1, 1, 1, 1, 1, 300, 0, 0, 0);
    idle();
    // Disabled clock ignores a sample
    smp(40, 0, 0);
    step(0, 1, 0, 1, 1, 999, 0, 0, 0);
    idle();
    // averaging disabled ignores a sample
    step(1, 0, 0, 1, 1, 888, 0, 0, 0);
    // Reset mid-fill then clean refill
    smp(60, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    smp(50, 0, 0); smp(50, 0, 0); smp(50, 0, 0); smp(50, 0, 0);
    idle();
    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic en, aen, clr, rstn, sv, dd, dir;
      int   rate, amt;
      en   = ($urandom % 5) != 0;
      aen  = ($urandom % 10) != 0;
      clr  = ($urandom % 97) == 0;
      rstn = ($urandom % 151) != 0;
      sv   = ($urandom % 3) != 0;
      rate = (($urandom % 4) == 0) ? int'($urandom % 65536) : int'($urandom_range(900, 1100));
      dd   = ($urandom % 3) == 0;
      dir  = $urandom % 2;
      amt  = int'($urandom_range(0, 20));
      step(en, aen, clr, rstn, sv, rate, dd, dir, amt);
    end
    idle();
    idle();
    @(posedge clk);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rate_averaging.md
Name: rate_averaging

Overview:
Smooths raw period measurements from the rate tracker before they are used as the active rate. It keeps a power-of-two moving-average window of accepted rate samples and maintains a running sum. Samples flagged as large drift are rejected as outliers; a run of consecutive rejections flushes the window and forces a re-lock. It sits directly downstream of the rate accumulator and drift detector, inside the rate tracking path.

Parameters:
RATE_COUNTER_WIDTH, clks_alot_p::RATE_COUNTER_WIDTH (16), width of rate samples and drift amounts
AVG_DEPTH_LOG2, 3, log2 of window depth (DEPTH = 8); legal range 1..6
DRIFT_REJECT_THRESHOLD, 8, drift_amount_i strictly above this rejects a sample once the window is locked
REJECT_LIMIT, 3, number of consecutive rejections that triggers a flush/re-lock; legal range 1..15

Ports:
clk  input  1  system clock; the only clock
sync_rst_n  input  1  synchronous, active-low reset
clk_en  input  1  clock enable; all state other than reset holds when low
averaging_en_i  input  1  enables sample acceptance
clear_state_i  input  1  synchronous clear of all state (qualified by clk_en)
sample_valid_i  input  1  single-cycle strobe: sample_rate_i is a completed period
sample_rate_i  input  RATE_COUNTER_WIDTH  measured period in clk_en ticks
drift_detected_i  input  1  drift flag for this sample
drift_direction_i  input  clks_alot_p::drift_direction_e  drift sign for this sample
drift_amount_i  input  RATE_COUNTER_WIDTH  absolute drift magnitude
average_valid_o  output  1  high while the window is full (LOCKED)
average_rate_o  output  RATE_COUNTER_WIDTH  running sum >> AVG_DEPTH_LOG2
fill_count_o  output  AVG_DEPTH_LOG2+1  number of valid entries, 0..DEPTH
sample_rejected_o  output  1  one-cycle pulse when a sample is rejected
reject_direction_o  output  clks_alot_p::drift_direction_e  direction of the last rejected sample

Behaviour:
- Accept event: clk_en && averaging_en_i && sample_valid_i && !clear_state_i.
- Reset (sync_rst_n low): clears the buffer, running sum, write pointer, fill count and reject count. Sets state EMPTY and drives all outputs to 0. Reset is not qualified by clk_en.
- clear_state_i with clk_en: has the same effect as reset. It wins over a simultaneous sample, which is dropped.
- States: EMPTY, FILLING, LOCKED.
  - EMPTY -> FILLING on the first accepted sample.
  - FILLING -> LOCKED when fill_count reaches DEPTH.
  - LOCKED -> FILLING on a flush.
- Rejection applies only in LOCKED:
  - A sample is rejected when drift_detected_i && drift_amount_i > DRIFT_REJECT_THRESHOLD.
  - A rejected sample does not touch the buffer or sum.
  - It increments reject_count, pulses sample_rejected_o the next cycle and latches reject_direction_o.
  - Any non-rejected accepted sample resets reject_count to 0.
  - In EMPTY and FILLING, all accepted samples are stored regardless of drift.
- Flush: happens when a rejection brings reject_count to REJECT_LIMIT.
  - The buffer is invalidated, the rejected sample is written as entry 0, sum = that sample, fill_count = 1, pointer = 1, reject_count = 0.
  - State becomes FILLING and average_valid_o drops on the next cycle.
- Store, not full: buf[wr_ptr] <= sample; sum += sample; fill_count++.
- Store, full: sum <= sum - buf[wr_ptr] + sample, where buf[wr_ptr] is the oldest entry; then buf[wr_ptr] <= sample.
- wr_ptr is AVG_DEPTH_LOG2 bits and wraps naturally DEPTH-1 -> 0.
- Running sum width is RATE_COUNTER_WIDTH + AVG_DEPTH_LOG2. It can never overflow; no saturation logic.
- Latency: average_rate_o, average_valid_o, fill_count_o and sample_rejected_o are registered and reflect an accept event one clk_en-qualified cycle later.
- average_rate_o is updated every cycle from the registered sum. It is truncated, not rounded, and is meaningful only while average_valid_o is high.
- clk_en low: no state changes, outputs hold, and sample_rejected_o is held low on the following cycle. The pulse is only generated on an accepting cycle.

Decomposition:
- clks_alot_p gets:
  - AVG_DEPTH_LOG2_DEFAULT, DRIFT_REJECT_THRESHOLD_DEFAULT, REJECT_LIMIT_DEFAULT;
  - the state enum rate_avg_state_e {EMPTY, FILLING, LOCKED}.
- Reuse the existing drift_direction_e.
- One natural sub-module: rate_sample_ring, the DEPTH-entry circular buffer with wr_ptr, fill_count and oldest-entry read.
- rate_averaging keeps the FSM, rejection and sum logic.

Test Plan:
All scenarios use DEPTH=4, W=16, threshold 8, limit 3.
- Fill: accept 100, 102, 98, 100 -> fill_count 1..4; average_valid_o rises one cycle after the 4th sample; average_rate_o = 100.
- Slide: then accept 104 -> sum 404, average_rate_o = 101, fill_count stays 4, wr_ptr wraps to 1.
- Outlier: sample 150 with drift 20 -> sample_rejected_o pulses once, average stays 101. Then sample 101 (no drift) -> reject_count 0, average = (102+98+100+104... window) is updated normally.
- Re-lock: three consecutive 200s, each with drift 50 -> third triggers a flush, fill_count = 1, average_valid_o = 0. Three more 200s -> LOCKED, average_rate_o = 200.
- Priority: clear_state_i and sample_valid_i in the same cycle while LOCKED -> all outputs 0, state EMPTY, sample not stored. Also check that sample_valid_i with clk_en=0 is ignored.
- Reset mid-fill: sync_rst_n low after 2 samples -> all outputs 0 next cycle. After release, 4 new samples of 50 -> average 50, with no residue from the earlier samples.
